// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared types and encodings for the multicycle controller.
//   state_t     - 4-bit FSM state encoding (also exported on state_o)
//   op_class_t  - decoded opcode class
//   ALU_*       - ALU operation codes
//   SRCB_*      - alusrcb operand select encodings
//   PC_*        - pcsrc PC source encodings
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    ADDIEX = 4'd8,
    ADDIWB = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_LW      = 3'd1,
    CLS_SW      = 3'd2,
    CLS_BEQ     = 3'd3,
    CLS_J       = 3'd4,
    CLS_ADDI    = 3'd5,
    CLS_ILLEGAL = 3'd7
  } op_class_t;

  // Low-bit codes of the MSB=1 opcode group
  localparam int unsigned OPLO_LW   = 0;
  localparam int unsigned OPLO_SW   = 1;
  localparam int unsigned OPLO_BEQ  = 2;
  localparam int unsigned OPLO_J    = 3;
  localparam int unsigned OPLO_ADDI = 4;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_classifier.sv
// opcode_classifier: combinational opcode decode.
// Ports:
//   i_op      [OPW-1:0] opcode
//   o_class   op_class_t decoded class (CLS_ILLEGAL for unknown opcodes)
//   o_illegal 1 when the opcode is not a recognised instruction
module opcode_classifier
  import multicycle_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] i_op,
  output op_class_t      o_class,
  output logic           o_illegal
);

  logic [OPW-2:0] w_low;
  assign w_low = i_op[OPW-2:0];

  always_comb begin
    o_class = CLS_ILLEGAL;
    if (!i_op[OPW-1])                          o_class = CLS_RTYPE;
    else if (w_low == (OPW-1)'(OPLO_LW))       o_class = CLS_LW;
    else if (w_low == (OPW-1)'(OPLO_SW))       o_class = CLS_SW;
    else if (w_low == (OPW-1)'(OPLO_BEQ))      o_class = CLS_BEQ;
    else if (w_low == (OPW-1)'(OPLO_J))        o_class = CLS_J;
    else if (w_low == (OPW-1)'(OPLO_ADDI))     o_class = CLS_ADDI;
  end

  assign o_illegal = (o_class == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle datapath
// (fetch / decode / memory / ALU / branch / jump).
// Optional feature macro: CTRL_PERF_EN adds cycle_cnt / instr_cnt counters.
// Ports:
//   clk, reset (sync, active-high), op [OPW-1:0], zero, mem_ready
//   memread, memwrite, iord, irwrite        memory / IR control
//   regwrite, regdst, mem2reg               register-file control
//   alusrca, alusrcb[1:0], alucontrol[OPW-2:0]  ALU control
//   pcsrc[1:0], pcen                        PC control
//   instr_done, illegal                     retire / illegal-opcode pulses
//   state_o[3:0]                            current state (debug)
//   cycle_cnt, instr_cnt [CNTW-1:0]         only with CTRL_PERF_EN
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int unsigned OPW  = 4,
  parameter int unsigned CNTW = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           memread,
  output logic           memwrite,
  output logic           iord,
  output logic           irwrite,
  output logic           regwrite,
  output logic           regdst,
  output logic           mem2reg,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [OPW-2:0] alucontrol,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic           instr_done,
  output logic           illegal,
  output logic [3:0]     state_o
`ifdef CTRL_PERF_EN
  ,
  output logic [CNTW-1:0] cycle_cnt,
  output logic [CNTW-1:0] instr_cnt
`endif
);

  state_t    r_state;
  op_class_t w_class;
  logic      w_illegal;

  opcode_classifier #(.OPW(OPW)) u_classifier (
    .i_op      (op),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  assign state_o = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      unique case (r_state)
        FETCH:  if (mem_ready) r_state <= DECODE;
        DECODE: begin
          if (w_illegal) r_state <= FETCH;
          else begin
            case (w_class)
              CLS_LW, CLS_SW: r_state <= MEMADR;
              CLS_RTYPE:      r_state <= EXEC;
              CLS_ADDI:       r_state <= ADDIEX;
              CLS_BEQ:        r_state <= BRANCH;
              CLS_J:          r_state <= JUMP;
              default:        r_state <= FETCH;
            endcase
          end
        end
        MEMADR: begin
          if (w_class == CLS_SW)      r_state <= MEMWR;
          else if (w_class == CLS_LW) r_state <= MEMRD;
          else                        r_state <= FETCH;
        end
        MEMRD:  if (mem_ready) r_state <= MEMWB;
        MEMWR:  if (mem_ready) r_state <= FETCH;
        MEMWB:  r_state <= FETCH;
        EXEC:   r_state <= ALUWB;
        ALUWB:  r_state <= FETCH;
        ADDIEX: r_state <= ADDIWB;
        ADDIWB: r_state <= FETCH;
        BRANCH: r_state <= FETCH;
        JUMP:   r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Outputs decode from the state register; the handshake-qualified
  // strobes (irwrite/pcen in FETCH, instr_done in MEMWR, pcen in BRANCH)
  // must follow mem_ready/zero in the same cycle, so they cannot be
  // registered without adding latency.
  always_comb begin
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    mem2reg    = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    alucontrol = (OPW-1)'(ALU_ADD);
    pcsrc      = PC_ALU;
    pcen       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (r_state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
        end
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        illegal = w_illegal;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      MEMWB: begin
        regwrite   = 1'b1;
        mem2reg    = 1'b1;
        instr_done = 1'b1;
      end
      EXEC: begin
        alusrca    = 1'b1;
        alucontrol = op[OPW-2:0];
      end
      ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = (OPW-1)'(ALU_SUB);
        pcsrc      = PC_ALUOUT;
        pcen       = zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pcsrc      = PC_JUMP;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every side-effecting strobe, so an abandoned
    // instruction never writes state or retires.
    if (reset) begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

`ifdef CTRL_PERF_EN
  logic [CNTW-1:0] r_cycle_cnt;
  logic [CNTW-1:0] r_instr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNTW'(1);
      if (instr_done) r_instr_cnt <= r_instr_cnt + CNTW'(1);
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors for the multicycle
// controller. The driver pushes the hand-derived expected output vector
// for each cycle; a monitor pops and compares on the falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw, iord, irw, rw, rd, m2r, asa;
    logic [1:0] asb;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic       pcen, done, ill;
  } exp_t;

  typedef struct {
    exp_t  e;
    string nm;
  } item_t;

  // Hand-written expected vectors
  localparam exp_t R_F    = '{st:4'd0, asb:2'b01, default:'0};
  localparam exp_t F_R    = '{st:4'd0, mr:1'b1, irw:1'b1, pcen:1'b1, asb:2'b01, default:'0};
  localparam exp_t F_W    = '{st:4'd0, mr:1'b1, asb:2'b01, default:'0};
  localparam exp_t D      = '{st:4'd1, asb:2'b11, default:'0};
  localparam exp_t D_ILL  = '{st:4'd1, asb:2'b11, ill:1'b1, default:'0};
  localparam exp_t MA     = '{st:4'd2, asa:1'b1, asb:2'b10, default:'0};
  localparam exp_t MRD    = '{st:4'd3, mr:1'b1, iord:1'b1, default:'0};
  localparam exp_t MRD_RS = '{st:4'd3, iord:1'b1, default:'0};
  localparam exp_t MWB    = '{st:4'd4, rw:1'b1, m2r:1'b1, done:1'b1, default:'0};
  localparam exp_t MWR_W  = '{st:4'd5, mw:1'b1, iord:1'b1, default:'0};
  localparam exp_t MWR_R  = '{st:4'd5, mw:1'b1, iord:1'b1, done:1'b1, default:'0};
  localparam exp_t EX6    = '{st:4'd6, asa:1'b1, alu:3'd6, default:'0};
  localparam exp_t AWB    = '{st:4'd7, rw:1'b1, rd:1'b1, done:1'b1, default:'0};
  localparam exp_t AIE    = '{st:4'd8, asa:1'b1, asb:2'b10, default:'0};
  localparam exp_t AIW    = '{st:4'd9, rw:1'b1, done:1'b1, default:'0};
  localparam exp_t BR_Z   = '{st:4'd10, asa:1'b1, alu:3'd1, pcs:2'b01, pcen:1'b1, done:1'b1, default:'0};
  localparam exp_t BR_NZ  = '{st:4'd10, asa:1'b1, alu:3'd1, pcs:2'b01, done:1'b1, default:'0};
  localparam exp_t JMP    = '{st:4'd11, pcs:2'b10, pcen:1'b1, done:1'b1, default:'0};

  localparam logic [3:0] OP_LW = 4'b1000, OP_SW = 4'b1001, OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_J = 4'b1011, OP_ADDI = 4'b1100, OP_R6 = 4'b0110;
  localparam logic [3:0] OP_BAD = 4'b1111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] op = OP_LW;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       memread, memwrite, iord, irwrite, regwrite, regdst, mem2reg;
  logic       alusrca, pcen, instr_done, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;
  item_t q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.OPW(4), .CNTW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .memread    (memread),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .mem2reg    (mem2reg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state_o    (state_o)
`ifdef CTRL_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  // Monitor: the DUT presents a control vector every cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      exp_t  act;
      it  = q.pop_front();
      act = '{st:state_o, mr:memread, mw:memwrite, iord:iord, irw:irwrite,
              rw:regwrite, rd:regdst, m2r:mem2reg, asa:alusrca, asb:alusrcb,
              alu:alucontrol, pcs:pcsrc, pcen:pcen, done:instr_done, ill:illegal};
      total++;
      if (act !== it.e) begin
        bad++;
        $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                 it.nm, act, it.e, act.st, it.e.st);
      end
    end
  end

  task automatic cyc(input logic rst, input logic mr, input logic z,
                     input logic [3:0] o, input exp_t e, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = mr;
    zero      = z;
    op        = o;
    it.e  = e;
    it.nm = nm;
    q.push_back(it);
  endtask

  initial begin
    // Reset held 3 cycles, then first fetch
    cyc(1, 1, 0, OP_LW, R_F, "rst0");
    cyc(1, 1, 0, OP_LW, R_F, "rst1");
    cyc(1, 1, 0, OP_LW, R_F, "rst2");
    cyc(0, 1, 0, OP_LW, F_R, "first_fetch");
    // LW, no wait states: 5 cycles
    cyc(0, 1, 0, OP_LW, D,   "lw_dec");
    cyc(0, 1, 0, OP_LW, MA,  "lw_adr");
    cyc(0, 1, 0, OP_LW, MRD, "lw_rd");
    cyc(0, 1, 0, OP_LW, MWB, "lw_wb");
    // SW with two wait cycles in MEMWR
    cyc(0, 1, 0, OP_SW, F_R,   "sw_fetch");
    cyc(0, 1, 0, OP_SW, D,     "sw_dec");
    cyc(0, 1, 0, OP_SW, MA,    "sw_adr");
    cyc(0, 0, 0, OP_SW, MWR_W, "sw_wait0");
    cyc(0, 0, 0, OP_SW, MWR_W, "sw_wait1");
    cyc(0, 1, 0, OP_SW, MWR_R, "sw_done");
    // R-type with a fetch wait
    cyc(0, 0, 0, OP_R6, F_W, "r_fetch_wait");
    cyc(0, 1, 0, OP_R6, F_R, "r_fetch");
    cyc(0, 1, 0, OP_R6, D,   "r_dec");
    cyc(0, 1, 0, OP_R6, EX6, "r_exec");
    cyc(0, 1, 0, OP_R6, AWB, "r_wb");
    // ADDI
    cyc(0, 1, 0, OP_ADDI, F_R, "addi_fetch");
    cyc(0, 1, 0, OP_ADDI, D,   "addi_dec");
    cyc(0, 1, 0, OP_ADDI, AIE, "addi_ex");
    cyc(0, 1, 0, OP_ADDI, AIW, "addi_wb");
    // BEQ taken then not taken
    cyc(0, 1, 0, OP_BEQ, F_R,   "beq1_fetch");
    cyc(0, 1, 0, OP_BEQ, D,     "beq1_dec");
    cyc(0, 1, 1, OP_BEQ, BR_Z,  "beq_taken");
    cyc(0, 1, 0, OP_BEQ, F_R,   "beq2_fetch");
    cyc(0, 1, 0, OP_BEQ, D,     "beq2_dec");
    cyc(0, 1, 0, OP_BEQ, BR_NZ, "beq_not_taken");
    // J
    cyc(0, 1, 0, OP_J, F_R, "j_fetch");
    cyc(0, 1, 0, OP_J, D,   "j_dec");
    cyc(0, 1, 0, OP_J, JMP, "j_jump");
    // Illegal opcode
    cyc(0, 1, 0, OP_BAD, F_R,   "ill_fetch");
    cyc(0, 1, 0, OP_BAD, D_ILL, "ill_dec");
    cyc(0, 1, 0, OP_LW,  F_R,   "ill_next_fetch");
    // LW abandoned by reset in MEMRD
    cyc(0, 1, 0, OP_LW, D,      "ab_dec");
    cyc(0, 1, 0, OP_LW, MA,     "ab_adr");
    cyc(0, 0, 0, OP_LW, MRD,    "ab_rd_wait");
    cyc(1, 1, 0, OP_LW, MRD_RS, "ab_rd_reset");
    cyc(1, 1, 0, OP_LW, R_F,    "ab_in_reset");
`ifdef CTRL_PERF_EN
    @(negedge clk);
    total++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      bad++;
      $display("FAIL cnt_after_reset: got cycle=%0d instr=%0d expected 0 0",
               cycle_cnt, instr_cnt);
    end
`endif
    cyc(0, 1, 0, OP_J, F_R, "post_fetch");
    cyc(0, 1, 0, OP_J, D,   "post_dec");
    cyc(0, 1, 0, OP_J, JMP, "post_jump");
    cyc(0, 1, 0, OP_J, F_R, "post_fetch2");
`ifdef CTRL_PERF_EN
    // After F,D,JUMP retire: 3 non-reset cycles counted, 1 instruction
    @(negedge clk);
    total++;
    if (cycle_cnt !== 32'd3 || instr_cnt !== 32'd1) begin
      bad++;
      $display("FAIL cnt_after_jump: got cycle=%0d instr=%0d expected 3 1",
               cycle_cnt, instr_cnt);
    end
`endif
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
